// File: rtl/cpu16_pkg.sv
// Shared widths and writeback request type for the 16-bit CPU register file.
package cpu16_pkg;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2**ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback, issue/hazard and register-file write signals of the writeback arbiter.
interface regfile_wb_if;
  import cpu16_pkg::*;
  logic              alu_valid, alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic              issue_valid, issue_ready;
  logic [ADDR_W-1:0] issue_rd, rs_addr, rt_addr;
  logic              rs_busy, rt_busy;
  logic              RegWrite;
  logic [ADDR_W-1:0] RD;
  logic [DATA_W-1:0] WriteData;

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
           issue_valid, issue_rd, rs_addr, rt_addr,
    output alu_ready, issue_ready, rs_busy, rt_busy, RegWrite, RD, WriteData
  );
  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
           issue_valid, issue_rd, rs_addr, rt_addr,
    input  alu_ready, issue_ready, rs_busy, rt_busy, RegWrite, RD, WriteData
  );
endinterface

// File: rtl/wb_load_fifo.sv
// Small circular FIFO for returning loads; push and pop may coincide when full.
module wb_load_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic          doPush, doPop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign head   = mem[rdPtr];

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= nxt(wrPtr);
      if (doPop)  rdPtr <= nxt(rdPtr);
      if (doPush && !doPop)      count <= count + 1'b1;
      else if (doPop && !doPush) count <= count - 1'b1;
    end

  // Payload storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clock)
    if (doPush) mem[wrPtr] <= din;
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Single write port of the register file: ALU/load arbitration, output register
// and per-register pending-write scoreboard for decode hazard stalls.
module regfile_wb_arbiter
  import cpu16_pkg::*;
#(
  parameter int LQ_DEPTH = 2,
  parameter int CNT_W    = 2
) (
  input logic         clock,
  input logic         reset,
  regfile_wb_if.slave wb
);
  wb_req_t             ldReq, ldHead, aluReq, grantReq;
  logic                lqFull, lqEmpty;
  logic                lastLoad, aluReady, grantLoad, grant, issueFire;
  logic [NUM_REGS-1:0] incV, decV;
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;

  assign ldReq  = '{rd: wb.ld_rd,  data: wb.ld_data};
  assign aluReq = '{rd: wb.alu_rd, data: wb.alu_data};

  wb_load_fifo #(.DEPTH(LQ_DEPTH), .W($bits(wb_req_t))) u_lq (
    .clock (clock),
    .reset (reset),
    .push  (wb.ld_valid),
    .pop   (grantLoad),
    .din   (ldReq),
    .head  (ldHead),
    .full  (lqFull),
    .empty (lqEmpty)
  );

  // A full queue must drain because loads cannot be back-pressured.
  always_comb begin
    aluReady  = 1'b1;
    grantLoad = 1'b0;
    if (lqFull) begin
      aluReady  = 1'b0;
      grantLoad = 1'b1;
    end else if (!lqEmpty) begin
      aluReady  = lastLoad;
      grantLoad = !(wb.alu_valid && lastLoad);
    end
  end

  assign wb.alu_ready = aluReady;
  assign grant        = grantLoad || (wb.alu_valid && aluReady);
  assign grantReq     = grantLoad ? ldHead : aluReq;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      lastLoad     <= 1'b1;
      wb.RegWrite  <= 1'b0;
      wb.RD        <= '0;
      wb.WriteData <= '0;
    end else begin
      wb.RegWrite <= grant;
      if (grant) begin
        lastLoad     <= grantLoad;
        wb.RD        <= grantReq.rd;
        wb.WriteData <= grantReq.data;
      end
    end

  assign issueFire      = wb.issue_valid && wb.issue_ready;
  assign wb.issue_ready = (cnt[wb.issue_rd] != '1);
  assign wb.rs_busy     = (cnt[wb.rs_addr] != '0);
  assign wb.rt_busy     = (cnt[wb.rt_addr] != '0);

  always_comb begin
    incV = '0;
    decV = '0;
    if (issueFire)   incV[wb.issue_rd] = 1'b1;
    if (wb.RegWrite) decV[wb.RD]       = 1'b1;
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) cnt <= '0;
    else
      for (int r = 0; r < NUM_REGS; r++) begin
        if (incV[r] && !decV[r])                      cnt[r] <= cnt[r] + 1'b1;
        else if (decV[r] && !incV[r] && cnt[r] != '0) cnt[r] <= cnt[r] - 1'b1;
      end

  // A commit with nothing outstanding means decode and writeback disagree.
  a_noUnderflow: assert property (@(posedge clock) disable iff (reset)
    wb.RegWrite |-> (cnt[wb.RD] != '0 || incV[wb.RD]));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed checks of arbitration, latency, scoreboard and async reset.
module tb_regfile_wb_arbiter;
  import cpu16_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   nChk  = 0;
  int   nFail = 0;

  regfile_wb_if bus();
  regfile_wb_arbiter #(.LQ_DEPTH(2), .CNT_W(2)) dut (
    .clock (clock),
    .reset (reset),
    .wb    (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        aV;
    logic [15:0] aD;
    logic        lV;
    logic [2:0]  lRd;
    logic [15:0] lD;
    logic        rdy;
    logic        wr;
    logic [2:0]  wRd;
    logic [15:0] wD;
  } vec_t;

  vec_t t3 [6];
  vec_t tf [7];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle;
    bus.alu_valid   = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_valid    = 1'b0; bus.ld_rd  = '0; bus.ld_data  = '0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0;
    bus.rs_addr     = '0;   bus.rt_addr  = '0;
  endtask

  task automatic doReset;
    idle();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    tick();
  endtask

  task automatic issue(input logic [2:0] rd, input int n);
    for (int i = 0; i < n; i++) begin
      bus.issue_valid = 1'b1;
      bus.issue_rd    = rd;
      tick();
    end
    bus.issue_valid = 1'b0;
  endtask

  task automatic aluW(input logic [2:0] rd, input logic [15:0] d);
    bus.alu_valid = 1'b1; bus.alu_rd = rd; bus.alu_data = d;
    tick();
    bus.alu_valid = 1'b0;
  endtask

  task automatic runVec(input string tag, input vec_t v);
    bus.alu_valid = v.aV; bus.alu_rd = 3'd1; bus.alu_data = v.aD;
    bus.ld_valid  = v.lV; bus.ld_rd  = v.lRd; bus.ld_data = v.lD;
    #1;
    chk({tag, " alu_ready"}, bus.alu_ready, v.rdy);
    tick();
    chk({tag, " RegWrite"}, bus.RegWrite, v.wr);
    if (v.wr) begin
      chk({tag, " RD"}, bus.RD, v.wRd);
      chk({tag, " WriteData"}, bus.WriteData, v.wD);
    end
  endtask

  initial begin
    t3 = '{
      '{1'b1, 16'h0100, 1'b1, 3'd6, 16'h6666, 1'b1, 1'b1, 3'd1, 16'h0100},
      '{1'b1, 16'h0101, 1'b1, 3'd7, 16'h7777, 1'b0, 1'b1, 3'd6, 16'h6666},
      '{1'b1, 16'h0101, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 3'd1, 16'h0101},
      '{1'b1, 16'h0102, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd7, 16'h7777},
      '{1'b1, 16'h0102, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 3'd1, 16'h0102},
      '{1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000}
    };
    tf = '{
      '{1'b1, 16'h0200, 1'b1, 3'd4, 16'h4444, 1'b1, 1'b1, 3'd1, 16'h0200},
      '{1'b1, 16'h0201, 1'b1, 3'd5, 16'h5555, 1'b0, 1'b1, 3'd4, 16'h4444},
      '{1'b1, 16'h0201, 1'b1, 3'd6, 16'h6666, 1'b1, 1'b1, 3'd1, 16'h0201},
      '{1'b1, 16'h0202, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd5, 16'h5555},
      '{1'b1, 16'h0202, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b1, 3'd1, 16'h0202},
      '{1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b0, 1'b1, 3'd6, 16'h6666},
      '{1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000}
    };

    idle();
    #12 reset = 1'b0;
    tick();

    // Reset state
    chk("rst RegWrite", bus.RegWrite, 1'b0);
    chk("rst RD", bus.RD, 3'd0);
    chk("rst WriteData", bus.WriteData, 16'h0000);
    chk("rst alu_ready", bus.alu_ready, 1'b1);
    chk("rst issue_ready", bus.issue_ready, 1'b1);
    chk("rst rs_busy", bus.rs_busy, 1'b0);

    // ALU only: one cycle to RegWrite
    issue(3'd3, 1);
    bus.rs_addr = 3'd3; #1;
    chk("t1 rs_busy pre", bus.rs_busy, 1'b1);
    bus.alu_valid = 1'b1; bus.alu_rd = 3'd3; bus.alu_data = 16'h1234; #1;
    chk("t1 alu_ready", bus.alu_ready, 1'b1);
    tick();
    bus.alu_valid = 1'b0;
    chk("t1 RegWrite", bus.RegWrite, 1'b1);
    chk("t1 RD", bus.RD, 3'd3);
    chk("t1 WriteData", bus.WriteData, 16'h1234);
    chk("t1 busy in write cycle", bus.rs_busy, 1'b1);
    tick();
    chk("t1 RegWrite off", bus.RegWrite, 1'b0);
    chk("t1 RD held", bus.RD, 3'd3);
    chk("t1 rs_busy cleared", bus.rs_busy, 1'b0);

    // Load only: two cycles to RegWrite, no bypass
    issue(3'd5, 1);
    bus.ld_valid = 1'b1; bus.ld_rd = 3'd5; bus.ld_data = 16'hBEEF;
    tick();
    bus.ld_valid = 1'b0;
    chk("t2 no bypass", bus.RegWrite, 1'b0);
    tick();
    chk("t2 RegWrite", bus.RegWrite, 1'b1);
    chk("t2 RD", bus.RD, 3'd5);
    chk("t2 WriteData", bus.WriteData, 16'hBEEF);
    tick();
    chk("t2 RegWrite off", bus.RegWrite, 1'b0);

    // Contention: alternate ALU and load, loads in order
    doReset();
    issue(3'd1, 3); issue(3'd6, 1); issue(3'd7, 1);
    for (int i = 0; i < 6; i++) runVec($sformatf("t3 c%0d", i), t3[i]);

    // Queue fills: load head forced out, ALU stalled
    doReset();
    issue(3'd1, 3); issue(3'd4, 1); issue(3'd5, 1); issue(3'd6, 1);
    for (int i = 0; i < 7; i++) runVec($sformatf("tf c%0d", i), tf[i]);
    bus.rs_addr = 3'd1; bus.rt_addr = 3'd6; #1;
    chk("tf rs_busy drained", bus.rs_busy, 1'b0);
    chk("tf rt_busy drained", bus.rt_busy, 1'b0);

    // Scoreboard saturation, busy tracking and same-cycle issue/commit
    doReset();
    issue(3'd2, 3);
    bus.issue_rd = 3'd2; #1;
    chk("t4 saturated", bus.issue_ready, 1'b0);
    bus.issue_rd = 3'd3; #1;
    chk("t4 other ready", bus.issue_ready, 1'b1);
    bus.rs_addr = 3'd2; bus.rt_addr = 3'd3; #1;
    chk("t4 rs_busy", bus.rs_busy, 1'b1);
    chk("t4 rt_busy", bus.rt_busy, 1'b0);
    aluW(3'd2, 16'h0A01);
    chk("t4 c1 RegWrite", bus.RegWrite, 1'b1);
    tick();
    aluW(3'd2, 16'h0A02);
    bus.issue_valid = 1'b1; bus.issue_rd = 3'd2; #1;
    chk("t4 issue with commit ready", bus.issue_ready, 1'b1);
    tick();
    bus.issue_valid = 1'b0; #1;
    chk("t4 count unchanged", bus.issue_ready, 1'b1);
    aluW(3'd2, 16'h0A03);
    tick();
    chk("t4 c3 rs_busy", bus.rs_busy, 1'b1);
    aluW(3'd2, 16'h0A04);
    chk("t4 c4 RD", bus.RD, 3'd2);
    chk("t4 c4 busy in write", bus.rs_busy, 1'b1);
    tick();
    chk("t4 c4 RegWrite off", bus.RegWrite, 1'b0);
    chk("t4 rs_busy cleared", bus.rs_busy, 1'b0);

    // Async reset mid-burst with two loads queued
    doReset();
    issue(3'd1, 3); issue(3'd4, 1); issue(3'd5, 1); issue(3'd6, 1);
    for (int i = 0; i < 3; i++) runVec($sformatf("t5 c%0d", i), tf[i]);
    #2 reset = 1'b1;
    #1;
    chk("t5 async RegWrite", bus.RegWrite, 1'b0);
    chk("t5 async RD", bus.RD, 3'd0);
    chk("t5 async WriteData", bus.WriteData, 16'h0000);
    idle();
    #2 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t5 no stale write %0d", i), bus.RegWrite, 1'b0);
    end
    for (int r = 0; r < 8; r++) begin
      bus.rs_addr = 3'(r); #1;
      chk($sformatf("t5 busy r%0d", r), bus.rs_busy, 1'b0);
    end
    chk("t5 alu_ready", bus.alu_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
    $finish;
  end
endmodule
